field_unit_cfg_ctrl: RTL
========================

Name: field_unit_cfg_ctrl

Overview:
- Configuration controller for a bank of NUM_FIELDS single-field units, each holding a 2^ADDR_WIDTH-entry instruction memory of {4-bit LU control, DATA_WIDTH data}.
- After reset, walks every memory entry and writes a default word.
- Then arbitrates rule writes round-robin between two requesters: host control plane (port A) and a learn engine (port B).
- Drives the per-unit write enables, the shared write address and the shared write data.

Parameters:
- DATA_WIDTH, 32, header field / LU data width; memory word is DATA_WIDTH+4.
- ADDR_WIDTH, 2, instruction memory address width (PDR_ID space).
- NUM_FIELDS, 4, number of field units driven; at least 2.
- INIT_CTRL, 4'h0, LU control nibble written during init.
- INIT_DATA, 0, data written during init.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- a_valid  in  1  host write request.
- a_ready  out  1  host request accepted when a_valid && a_ready.
- a_sel  in  FSW  target field unit index; FSW = $clog2(NUM_FIELDS).
- a_addr  in  ADDR_WIDTH  target entry.
- a_word  in  DATA_WIDTH+4  {control[3:0], data}.
- b_valid, b_ready, b_sel, b_addr, b_word  same widths and meaning for the learn port.
- we  out  NUM_FIELDS  one-hot write enable per field unit.
- w_addr  out  ADDR_WIDTH  shared write address.
- wd  out  DATA_WIDTH+4  shared write data.
- init_done  out  1  high once the init walk completes.
- sel_err  out  1  one-cycle pulse: an accepted request had sel >= NUM_FIELDS.

Behaviour:
- Clocking: single clock. Reset is synchronous, active-high; clock port clk, reset port rst.
- Reset values: we=0, w_addr=0, wd=0, init_done=0, sel_err=0, a_ready=b_ready=0, init counter=0, round-robin pointer=A.
- FSM states: INIT, RUN.
- INIT:
  - Each cycle drives we=all ones, w_addr=cnt, wd={INIT_CTRL,INIT_DATA}; cnt increments.
  - After cnt = 2^ADDR_WIDTH-1 is written, next state is RUN and init_done=1 (sticky until rst).
  - Init takes exactly 2^ADDR_WIDTH cycles after reset deassertion.
  - Both ready outputs are 0 throughout INIT.
- RUN:
  - a_ready/b_ready are combinational grants.
  - Only one valid: that port is granted.
  - Both valid: the port not granted last is granted, and the pointer updates on grant.
  - No valid: both ready=0 and the pointer holds.
- Write timing:
  - Accepted request in cycle N produces we=onehot(sel), w_addr=addr, wd=word in cycle N+1, all registered.
  - we=0 in any cycle without an acceptance in the previous cycle.
  - Throughput is one write per cycle, with no bubble between back-to-back grants.
- Invalid target:
  - sel >= NUM_FIELDS: request is still accepted (ready=1) and dropped.
  - we stays 0 in N+1 and sel_err=1 in N+1.
  - The pointer still advances.
- Ordering: same-cycle conflicts are resolved purely by the pointer. Writes to the same entry land in grant order, so the later grant wins.
- Reset mid-operation:
  - Any cycle with rst=1 restores reset values; a pending registered write is discarded.
  - Init restarts from cnt=0 after rst deasserts.
- Ready never depends on the requester's own sel or word. Valid may drop without acceptance; no sticky requirement.

Optional Feature:
- Macro CFG_CTRL_BCAST_EN.
- Defined:
  - Each port gains a 1-bit input a_bcast/b_bcast.
  - An accepted request with bcast=1 writes we=all ones, ignores sel and never raises sel_err.
- Undefined:
  - The bcast ports do not exist.
  - we is always one-hot or zero in RUN.

Decomposition:
- Shared package field_unit_pkg holds:
  - state typedef {INIT, RUN}.
  - localparam WORD_W = DATA_WIDTH+4.
  - the control nibble field offsets, [WORD_W-1:DATA_WIDTH] = control and [DATA_WIDTH-1:0] = data.
- One sub-module, rr_arb2: two-requester round-robin arbiter with pointer state. It is reused by future multi-port controllers.
- Init walker and write register stay in the top module.

Test Plan:
1. Reset, then idle: we=4'b1111 with w_addr 0,1,2,3 on cycles 1-4, wd=36'h0. init_done rises after cycle 4; no ready before that.
2. Single host write: a_valid, a_sel=2, a_addr=1, a_word=36'h5_DEADBEEF accepted in cycle N. In N+1: we=4'b0100, w_addr=1, wd=36'h5_DEADBEEF. In N+2: we=0.
3. Contention: A and B valid for 4 cycles after init. Grants alternate A,B,A,B (pointer starts at A). we follows each port's sel one cycle later.
4. Bad select: b_sel=3 with NUM_FIELDS=3 is accepted. Next cycle: we=0, sel_err=1. Following cycle: sel_err=0.
5. Reset mid-RUN: rst asserted the same cycle a request is accepted. That write never appears; init replays 4 cycles; ready stays low until init_done.
6. With CFG_CTRL_BCAST_EN: a_bcast=1, a_addr=3 gives we=4'b1111, w_addr=3 next cycle, and no sel_err.

Source files
------------

// File: rtl/field_unit_cfg_ctrl_pkg.sv
// Shared definitions for the field-unit configuration path: state encoding
// and the {control, data} layout of an instruction-memory word.
package field_unit_pkg;

    localparam int CTRL_W         = 4;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int WORD_W         = DEF_DATA_WIDTH + CTRL_W;

    typedef logic [0:0] state_t;
    localparam state_t ST_INIT = 1'b0;
    localparam state_t ST_RUN  = 1'b1;

    // Control nibble sits above the data field: [WORD_W-1:DATA_WIDTH].
    function automatic int ctrl_lsb(input int data_width);
        return data_width;
    endfunction

endpackage

// File: rtl/field_unit_cfg_ctrl_if.sv
// Write-request port of the configuration controller (valid/ready handshake).
// With CFG_CTRL_BCAST_EN defined the port carries a broadcast flag.
interface field_unit_cfg_ctrl_if #(
    parameter int ADDR_WIDTH = 2,
    parameter int WORD_W     = 36,
    parameter int FSW        = 2
);
    logic                  valid;
    logic                  ready;
    logic [FSW-1:0]        sel;
    logic [ADDR_WIDTH-1:0] addr;
    logic [WORD_W-1:0]     word;
`ifdef CFG_CTRL_BCAST_EN
    logic                  bcast;

    modport master (output valid, sel, addr, word, bcast, input ready);
    modport slave  (input valid, sel, addr, word, bcast, output ready);
`else
    modport master (output valid, sel, addr, word, input ready);
    modport slave  (input valid, sel, addr, word, output ready);
`endif
endinterface

// File: rtl/field_unit_cfg_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter; the pointer names the port that wins
// the next conflict and flips to the other side after every grant.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    logic ptr_q, ptr_d;

    always_comb begin
        gnt   = 2'b00;
        ptr_d = ptr_q;
        if (en) begin
            if (req == 2'b11) gnt = ptr_q ? 2'b10 : 2'b01;
            else              gnt = req;
        end
        if (gnt[0]) ptr_d = 1'b1;
        if (gnt[1]) ptr_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) ptr_q <= 1'b0;
        else     ptr_q <= ptr_d;
    end
endmodule

// File: rtl/field_unit_cfg_ctrl.sv
// Config controller: walks every entry with a default word after reset, then
// arbitrates host (a) and learn (b) writes. Optional: CFG_CTRL_BCAST_EN.
module field_unit_cfg_ctrl
    import field_unit_pkg::*;
#(
    parameter int                   DATA_WIDTH = 32,
    parameter int                   ADDR_WIDTH = 2,
    parameter int                   NUM_FIELDS = 4,
    parameter logic [CTRL_W-1:0]    INIT_CTRL  = 4'h0,
    parameter logic [DATA_WIDTH-1:0] INIT_DATA = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    field_unit_cfg_ctrl_if.slave       a,
    field_unit_cfg_ctrl_if.slave       b,
    output logic [NUM_FIELDS-1:0]      we,
    output logic [ADDR_WIDTH-1:0]      w_addr,
    output logic [DATA_WIDTH+CTRL_W-1:0] wd,
    output logic                       init_done,
    output logic                       sel_err
);
    localparam int FSW = $clog2(NUM_FIELDS);
    localparam int WW  = DATA_WIDTH + CTRL_W;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  init_done_q, init_done_d;
    logic [NUM_FIELDS-1:0] we_q, we_d;
    logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
    logic [WW-1:0]         wd_q, wd_d;
    logic                  sel_err_q, sel_err_d;

    logic [1:0]            gnt;
    logic [FSW-1:0]        acc_sel;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic [WW-1:0]         acc_word;
    logic                  acc_bcast;

    rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .en  (state_q == ST_RUN),
        .req ({b.valid, a.valid}),
        .gnt (gnt)
    );

    assign a.ready = gnt[0];
    assign b.ready = gnt[1];

    assign acc_sel  = gnt[1] ? b.sel  : a.sel;
    assign acc_addr = gnt[1] ? b.addr : a.addr;
    assign acc_word = gnt[1] ? b.word : a.word;
`ifdef CFG_CTRL_BCAST_EN
    assign acc_bcast = gnt[1] ? b.bcast : a.bcast;
`else
    assign acc_bcast = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_done_d = init_done_q;
        we_d        = '0;
        w_addr_d    = w_addr_q;
        wd_d        = wd_q;
        sel_err_d   = 1'b0;
        if (state_q == ST_INIT) begin
            we_d     = '1;
            w_addr_d = cnt_q;
            wd_d     = {INIT_CTRL, INIT_DATA};
            cnt_d    = cnt_q + 1'b1;
            if (&cnt_q) begin
                state_d     = ST_RUN;
                init_done_d = 1'b1;
            end
        end else if (|gnt) begin
            w_addr_d = acc_addr;
            wd_d     = acc_word;
            // Out-of-range selects are still accepted; they just write nothing.
            if (acc_bcast)
                we_d = '1;
            else if (int'(acc_sel) < NUM_FIELDS)
                for (int i = 0; i < NUM_FIELDS; i++) we_d[i] = (acc_sel == FSW'(i));
            else
                sel_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
            we_q        <= '0;
            w_addr_q    <= '0;
            wd_q        <= '0;
            sel_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
            we_q        <= we_d;
            w_addr_q    <= w_addr_d;
            wd_q        <= wd_d;
            sel_err_q   <= sel_err_d;
        end
    end

    assign we        = we_q;
    assign w_addr    = w_addr_q;
    assign wd        = wd_q;
    assign init_done = init_done_q;
    assign sel_err   = sel_err_q;
endmodule
